fb_meas_ctrl: RTL and testbench

Measurement scheduler for the two wheel-encoder feedback pulse inputs (left/right) of the motor subsystem, running on the 125 MHz system clock.
- Generates a programmable gate window, counts rising edges per channel inside each window, and snapshots both counts at window end.
- Delivers the snapshot over a valid/ready stream, left then right, to the speed-control logic.
- Replaces free-running fixed 1 s windows with software-configurable, start/stop-controlled, back-pressure-aware windows.

---
 rtl/fb_meas_ctrl_pkg.sv | 23 ++
 rtl/fb_meas_ctrl_if.sv | 30 +++
 rtl/fb_edge_cnt.sv | 92 +++++++++
 rtl/fb_meas_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fb_meas_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_meas_ctrl_pkg.sv
// Shared definitions for the wheel-encoder feedback measurement block:
// default widths, stream channel encoding and the two FSM state types.
package fb_meas_ctrl_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_PER_W  = 27;
    localparam int DEF_DROP_W = 8;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RUN  = 1'b1
    } win_state_e;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_L    = 2'd1,
        O_R    = 2'd2
    } out_state_e;

endpackage

// File: rtl/fb_meas_ctrl_if.sv
// Valid/ready stream carrying one channel count word per beat.
interface fb_meas_ctrl_if
    import fb_meas_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             meas_valid;
    logic             meas_ready;
    logic             meas_ch;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_ovf;

    modport master (
        output meas_valid,
        output meas_ch,
        output meas_cnt,
        output meas_ovf,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  meas_ch,
        input  meas_cnt,
        input  meas_ovf,
        output meas_ready
    );

endinterface

// File: rtl/fb_edge_cnt.sv
// One feedback channel: 2-FF synchroniser, rising-edge detect, saturating
// edge counter with overflow flag, and a snapshot register loaded on demand.
module fb_edge_cnt
    import fb_meas_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             pulse_i,    // asynchronous encoder pin
    input  logic             clr_i,      // restart count at 0 next cycle
    input  logic             load_i,     // capture live count into snapshot
    output logic [CNT_W-1:0] snap_cnt_o,
    output logic             snap_ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = {{(CNT_W-1){1'b1}}, 1'b0};

    logic             sync1_q, sync2_q, prev_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_live;
    logic             ovf_q, ovf_d, ovf_live;
    logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic             snap_ovf_q, snap_ovf_d;

    assign rise = sync2_q & ~prev_q;

    // Synchroniser chain and edge-detect history.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Live count includes this cycle's edge so a window-end edge is captured.
    // NOTE: defaults first so every path assigns every signal; no latches.
    always_comb begin
        cnt_live   = cnt_q;
        ovf_live   = ovf_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        snap_cnt_d = snap_cnt_q;
        snap_ovf_d = snap_ovf_q;
        if (rise) begin
            if (cnt_q != CNT_MAX) begin
                cnt_live = cnt_q + CNT_W'(1);
            end
            // Flag an edge landing on, or pushing the count to, all-ones.
            if (cnt_q == CNT_MAX || cnt_q == CNT_NEAR) begin
                ovf_live = 1'b1;
            end
        end
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            cnt_d = cnt_live;
            ovf_d = ovf_live;
        end
        if (load_i) begin
            snap_cnt_d = cnt_live;
            snap_ovf_d = ovf_live;
        end
    end

    // Counter and snapshot registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            snap_cnt_q <= '0;
            snap_ovf_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            snap_cnt_q <= snap_cnt_d;
            snap_ovf_q <= snap_ovf_d;
        end
    end

    assign snap_cnt_o = snap_cnt_q;
    assign snap_ovf_o = snap_ovf_q;

endmodule

// File: rtl/fb_meas_ctrl.sv
// Feedback measurement scheduler: programmable gate windows over both
// encoder channels, snapshot at window end, left/right words streamed out
// through a single-snapshot buffer with overrun counting.
module fb_meas_ctrl
    import fb_meas_ctrl_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PER_W  = DEF_PER_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cfg_en,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic              inp_fbp_l,
    input  logic              inp_fbp_r,
    fb_meas_ctrl_if.master    meas,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    win_state_e        win_q, win_d;
    out_state_e        out_q, out_d;
    logic [PER_W-1:0]  win_cnt_q, win_cnt_d;
    logic [PER_W-1:0]  last_q, last_d;      // latched P-1 for the current window
    logic [PER_W-1:0]  eff_last;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              win_end;
    logic              clr;
    logic              load;
    logic              drop_hit;
    logic              hs;
    logic [CNT_W-1:0]  snap_cnt_l, snap_cnt_r;
    logic              snap_ovf_l, snap_ovf_r;

    // Periods below 2 are stretched to 2 so a window always has an end cycle.
    assign eff_last = (cfg_period < PER_W'(2)) ? PER_W'(1) : cfg_period - PER_W'(1);
    assign win_end  = (win_q == W_RUN) && (win_cnt_q == last_q);
    assign clr      = (win_q != W_RUN) || win_end;
    assign hs       = (out_q != O_IDLE) && meas.meas_ready;

    fb_edge_cnt #(.CNT_W(CNT_W)) u_cnt_l (
        .clk        (clk),
        .n_rst      (n_rst),
        .pulse_i    (inp_fbp_l),
        .clr_i      (clr),
        .load_i     (load),
        .snap_cnt_o (snap_cnt_l),
        .snap_ovf_o (snap_ovf_l)
    );

    fb_edge_cnt #(.CNT_W(CNT_W)) u_cnt_r (
        .clk        (clk),
        .n_rst      (n_rst),
        .pulse_i    (inp_fbp_r),
        .clr_i      (clr),
        .load_i     (load),
        .snap_cnt_o (snap_cnt_r),
        .snap_ovf_o (snap_ovf_r)
    );

    // Window FSM: start on enable, wrap back-to-back, abort on disable.
    always_comb begin
        win_d     = win_q;
        win_cnt_d = win_cnt_q;
        last_d    = last_q;
        case (win_q)
            W_IDLE: begin
                if (cfg_en) begin
                    win_d     = W_RUN;
                    win_cnt_d = '0;
                    last_d    = eff_last;
                end
            end
            W_RUN: begin
                if (win_end) begin
                    // Snapshot is taken even if enable drops on this cycle.
                    win_cnt_d = '0;
                    last_d    = eff_last;
                    if (!cfg_en) begin
                        win_d = W_IDLE;
                    end
                end else if (!cfg_en) begin
                    win_d     = W_IDLE;
                    win_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + PER_W'(1);
                end
            end
            default: begin
                win_d = W_IDLE;
            end
        endcase
    end

    // Output FSM: present left then right; reload with no bubble from O_R.
    always_comb begin
        out_d    = out_q;
        load     = 1'b0;
        drop_hit = 1'b0;
        case (out_q)
            O_IDLE: begin
                if (win_end) begin
                    load  = 1'b1;
                    out_d = O_L;
                end
            end
            O_L: begin
                if (hs) begin
                    out_d = O_R;
                end
                if (win_end) begin
                    drop_hit = 1'b1;
                end
            end
            O_R: begin
                if (hs) begin
                    if (win_end) begin
                        load  = 1'b1;
                        out_d = O_L;
                    end else begin
                        out_d = O_IDLE;
                    end
                end else if (win_end) begin
                    drop_hit = 1'b1;
                end
            end
            default: begin
                out_d = O_IDLE;
            end
        endcase
    end

    // Dropped-snapshot counter saturates at all-ones.
    always_comb begin
        drop_d = drop_q;
        if (drop_hit && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // State registers for both FSMs and the drop counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_q     <= W_IDLE;
            out_q     <= O_IDLE;
            win_cnt_q <= '0;
            last_q    <= '0;
            drop_q    <= '0;
        end else begin
            win_q     <= win_d;
            out_q     <= out_d;
            win_cnt_q <= win_cnt_d;
            last_q    <= last_d;
            drop_q    <= drop_d;
        end
    end

    assign busy            = (win_q == W_RUN);
    assign drop_cnt        = drop_q;
    assign meas.meas_valid = (out_q != O_IDLE);
    assign meas.meas_ch    = (out_q == O_R) ? CH_R : CH_L;
    assign meas.meas_cnt   = (out_q == O_R) ? snap_cnt_r : snap_cnt_l;
    assign meas.meas_ovf   = (out_q == O_R) ? snap_ovf_r : snap_ovf_l;

endmodule

// File: tb/tb_fb_meas_ctrl.sv
// Directed bench for fb_meas_ctrl: expected words queued as stimulus is
// driven, popped by a stream monitor; a CNT_W=4 copy covers saturation.
module tb_fb_meas_ctrl;
    import fb_meas_ctrl_pkg::*;

    typedef struct packed {
        logic        ch;
        logic [15:0] cnt;
        logic        ovf;
    } word_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cfg_en;
    logic [26:0] cfg_period;
    logic        inp_fbp_l;
    logic        inp_fbp_r;
    logic        busy_m, busy_s;
    logic [7:0]  drop_m, drop_s;

    int    compared   = 0;
    int    mismatched = 0;
    int    now_c      = 0;
    word_t exp_q[$];
    word_t mon_got, mon_want;

    fb_meas_ctrl_if #(.CNT_W(16)) meas_m ();
    fb_meas_ctrl_if #(.CNT_W(4))  meas_s ();

    assign meas_s.meas_ready = 1'b1;

    fb_meas_ctrl #(.CNT_W(16), .PER_W(27), .DROP_W(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cfg_en     (cfg_en),
        .cfg_period (cfg_period),
        .inp_fbp_l  (inp_fbp_l),
        .inp_fbp_r  (inp_fbp_r),
        .meas       (meas_m),
        .busy       (busy_m),
        .drop_cnt   (drop_m)
    );

    fb_meas_ctrl #(.CNT_W(4), .PER_W(27), .DROP_W(8)) dut_s (
        .clk        (clk),
        .n_rst      (n_rst),
        .cfg_en     (cfg_en),
        .cfg_period (cfg_period),
        .inp_fbp_l  (inp_fbp_l),
        .inp_fbp_r  (inp_fbp_r),
        .meas       (meas_s),
        .busy       (busy_s),
        .drop_cnt   (drop_s)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            now_c++;
        end
    endtask

    task automatic at(input int c);
        if (c > now_c) step(c - now_c);
    endtask

    task automatic pulse(input logic l, input logic r);
        inp_fbp_l = l;
        inp_fbp_r = r;
        step(1);
        inp_fbp_l = 1'b0;
        inp_fbp_r = 1'b0;
    endtask

    task automatic start_run(input int period);
        cfg_period = 27'(period);
        cfg_en     = 1'b1;
        step(1);
        now_c = 0;
    endtask

    task automatic push_snap(input int l, input int r);
        exp_q.push_back('{ch: CH_L, cnt: 16'(l), ovf: 1'b0});
        exp_q.push_back('{ch: CH_R, cnt: 16'(r), ovf: 1'b0});
    endtask

    // Stream monitor: every accepted word must match the head of the queue.
    always @(negedge clk) begin
        if (n_rst && meas_m.meas_valid && meas_m.meas_ready) begin
            mon_got = '{ch: meas_m.meas_ch, cnt: meas_m.meas_cnt, ovf: meas_m.meas_ovf};
            compared++;
            assert (exp_q.size() > 0) else begin
                mismatched++;
                $error("FAIL unexpected_word: observed %h with nothing expected", mon_got);
            end
            if (exp_q.size() > 0) begin
                mon_want = exp_q.pop_front();
                compared++;
                assert (mon_got === mon_want) else begin
                    mismatched++;
                    $error("FAIL stream_word: observed %h expected %h", mon_got, mon_want);
                end
            end
        end
    end

    initial begin
        n_rst              = 1'b0;
        cfg_en             = 1'b0;
        cfg_period         = '0;
        inp_fbp_l          = 1'b0;
        inp_fbp_r          = 1'b0;
        meas_m.meas_ready  = 1'b1;

        // Reset state
        step(2);
        check("rst_valid", meas_m.meas_valid, 0);
        check("rst_ch",    meas_m.meas_ch,    0);
        check("rst_cnt",   meas_m.meas_cnt,   0);
        check("rst_ovf",   meas_m.meas_ovf,   0);
        check("rst_busy",  busy_m,            0);
        check("rst_drop",  drop_m,            0);
        n_rst = 1'b1;
        step(2);

        // Pulses while disabled produce nothing
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b1);
            step(2);
        end
        step(4);
        check("idle_valid", meas_m.meas_valid, 0);
        check("idle_busy",  busy_m,            0);

        // Basic window, P=100: 7 left / 3 right edges
        start_run(100);
        check("basic_busy0", busy_m, 1);
        push_snap(7, 3);
        for (int i = 0; i < 7; i++) begin
            at(2 + 4 * i);
            pulse(1'b1, logic'(i < 3));
        end
        push_snap(0, 0);
        at(99);
        check("basic_pre_valid", meas_m.meas_valid, 0);
        at(100);
        check("basic_l_valid", meas_m.meas_valid, 1);
        check("basic_l_ch",    meas_m.meas_ch,    0);
        check("basic_l_cnt",   meas_m.meas_cnt,   7);
        check("basic_busy100", busy_m,            1);
        at(101);
        check("basic_r_valid", meas_m.meas_valid, 1);
        check("basic_r_ch",    meas_m.meas_ch,    1);
        check("basic_r_cnt",   meas_m.meas_cnt,   3);
        at(102);
        check("basic_post_valid", meas_m.meas_valid, 0);
        at(199);
        check("win2_pre_valid", meas_m.meas_valid, 0);
        at(200);
        check("win2_valid", meas_m.meas_valid, 1);

        // Abort at window cycle 30 of window 3: partial counts discarded
        at(210);
        pulse(1'b1, 1'b1);
        at(230);
        cfg_en = 1'b0;
        step(1);
        check("abort_busy", busy_m, 0);
        at(260);
        check("abort_valid", meas_m.meas_valid, 0);

        // Boundary edges, P=50: left edge on cycle 49, right edge on cycle 50
        start_run(50);
        push_snap(1, 0);
        push_snap(0, 1);
        at(47);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        at(50);
        check("bound_l_cnt", meas_m.meas_cnt, 1);
        at(120);
        cfg_en = 1'b0;
        step(1);
        check("bound_busy", busy_m, 0);

        // Back-pressure and drops, P=10, ready low for 35 cycles
        meas_m.meas_ready = 1'b0;
        start_run(10);
        push_snap(1, 0);
        at(2);
        pulse(1'b1, 1'b0);
        at(10);
        check("bp_valid10", meas_m.meas_valid, 1);
        check("bp_ch10",    meas_m.meas_ch,    0);
        check("bp_cnt10",   meas_m.meas_cnt,   1);
        at(12);
        pulse(1'b0, 1'b1);
        at(19);
        check("bp_drop19", drop_m, 0);
        at(22);
        pulse(1'b1, 1'b0);
        at(25);
        check("bp_hold_ch25",  meas_m.meas_ch,  0);
        check("bp_hold_cnt25", meas_m.meas_cnt, 1);
        push_snap(0, 2);
        at(31);
        pulse(1'b0, 1'b1);
        at(34);
        check("bp_drop34",     drop_m,            2);
        check("bp_hold_val34", meas_m.meas_valid, 1);
        check("bp_hold_cnt34", meas_m.meas_cnt,   1);
        pulse(1'b0, 1'b1);
        meas_m.meas_ready = 1'b1;
        check("bp_rel_ch35", meas_m.meas_ch, 0);
        at(36);
        check("bp_rel_ch36",  meas_m.meas_ch,  1);
        check("bp_rel_cnt36", meas_m.meas_cnt, 0);
        at(37);
        check("bp_gap_valid37", meas_m.meas_valid, 0);
        at(40);
        check("bp_next_valid40", meas_m.meas_valid, 1);
        at(45);
        cfg_en = 1'b0;
        step(1);
        at(50);
        check("bp_end_valid", meas_m.meas_valid, 0);

        // Minimum period: cfg_period=0 behaves as P=2, snapshots every 2 cycles
        start_run(0);
        for (int i = 0; i < 5; i++) push_snap(0, 0);
        exp_q[2] = '{ch: CH_L, cnt: 16'd1, ovf: 1'b0};
        pulse(1'b1, 1'b0);
        for (int c = 2; c < 12; c++) begin
            at(c);
            check("p2_valid", meas_m.meas_valid, 1);
            check("p2_ch",    meas_m.meas_ch,    32'(c % 2));
            if (c == 10) cfg_en = 1'b0;
        end
        check("p2_busy", busy_m, 0);
        at(13);
        check("p2_end_valid", meas_m.meas_valid, 0);
        check("p2_drop",      drop_m,            2);

        // Saturation on the CNT_W=4 copy: 20 right edges, 3 left edges
        start_run(100);
        push_snap(3, 20);
        for (int i = 0; i < 20; i++) begin
            at(2 + 4 * i);
            pulse(logic'(i < 3), 1'b1);
        end
        at(100);
        check("sat_l_valid", meas_s.meas_valid, 1);
        check("sat_l_ch",    meas_s.meas_ch,    0);
        check("sat_l_cnt",   meas_s.meas_cnt,   3);
        check("sat_l_ovf",   meas_s.meas_ovf,   0);
        at(101);
        check("sat_r_ch",    meas_s.meas_ch,    1);
        check("sat_r_cnt",   meas_s.meas_cnt,   15);
        check("sat_r_ovf",   meas_s.meas_ovf,   1);
        at(110);
        cfg_en = 1'b0;
        step(1);
        at(115);
        check("queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a window with a word held
        meas_m.meas_ready = 1'b0;
        start_run(10);
        at(2);
        pulse(1'b1, 1'b0);
        at(15);
        check("arst_pre_valid", meas_m.meas_valid, 1);
        check("arst_pre_cnt",   meas_m.meas_cnt,   1);
        check("arst_pre_busy",  busy_m,            1);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_valid", meas_m.meas_valid, 0);
        check("arst_ch",    meas_m.meas_ch,    0);
        check("arst_cnt",   meas_m.meas_cnt,   0);
        check("arst_ovf",   meas_m.meas_ovf,   0);
        check("arst_busy",  busy_m,            0);
        check("arst_drop",  drop_m,            0);
        exp_q.delete();
        cfg_en = 1'b0;
        step(2);
        n_rst = 1'b1;
        step(3);
        check("post_rst_valid", meas_m.meas_valid, 0);
        check("post_rst_busy",  busy_m,            0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
